fir_mac: RTL and testbench

FIR_MAC -- requirements
Module: fir_mac

---
 rtl/fir_filter_pkg.sv | 22 ++
 rtl/fir_delayline.sv | 34 +++
 rtl/fir_mac.sv | 128 ++++++++++++
 tb/tb_fir_mac.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fir_filter_pkg.sv
// Shared constants, FSM state type and fixed Q1.15 coefficient set for the FIR MAC datapath.
package fir_filter_pkg;

   localparam int DATABITS   = 16;
   localparam int COEFFBITS  = 16;
   localparam int TAPS       = 8;
   localparam int FRACBITS   = 15;
   localparam int ACCBITS    = DATABITS + COEFFBITS + $clog2(TAPS);
   localparam int CLK_PERIOD = 10;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      OUT
   } state_t;

   localparam logic signed [COEFFBITS-1:0] COEFFS [TAPS] = '{
      16'sh4000, 16'sh4000, 16'sh4000, 16'sh2000,
      16'sh1000, 16'sh0800, 16'sh0000, 16'sh0000
   };

endpackage

// File: rtl/fir_delayline.sv
// Circular sample history: one write port, one combinational indexed read port, flushable.
module fir_delayline #(
   parameter int DATABITS = 16,
   parameter int TAPS     = 8,
   parameter int PTRBITS  = $clog2(TAPS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                wr_en,
   input  logic [PTRBITS-1:0]  wr_addr,
   input  logic [DATABITS-1:0] wr_data,
   input  logic [PTRBITS-1:0]  rd_addr,
   output logic [DATABITS-1:0] rd_data
);

   logic [DATABITS-1:0] mem [TAPS];

   // NOTE: the history is reset and flushed explicitly because stale samples would leak into
   // the first TAPS-1 results; this keeps it in flops rather than a RAM macro.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < TAPS; i++) mem[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < TAPS; i++) mem[i] <= '0;
      end else if (wr_en) begin
         // NOTE: non-blocking so every reader in this edge sees the pre-edge contents.
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_mac.sv
// Serial FIR filter: one multiply-accumulate per cycle, saturated result with load/clear strobes
// for a downstream output register.
module fir_mac #(
   parameter int DATABITS  = fir_filter_pkg::DATABITS,
   parameter int COEFFBITS = fir_filter_pkg::COEFFBITS,
   parameter int TAPS      = fir_filter_pkg::TAPS,
   parameter int FRACBITS  = fir_filter_pkg::FRACBITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr_in,
   input  logic                valid_in,
   input  logic [DATABITS-1:0] data_in,
   output logic                ready_out,
   output logic [DATABITS-1:0] data_out,
   output logic                ld_out,
   output logic                clr_out,
   output logic                busy_out
);

   import fir_filter_pkg::*;

   localparam int PTRBITS = $clog2(TAPS);
   localparam int ACCBITS = DATABITS + COEFFBITS + PTRBITS;
   localparam logic [PTRBITS-1:0] LAST_TAP = PTRBITS'(TAPS - 1);
   localparam logic signed [ACCBITS-1:0] SAT_MAX =
      {{(ACCBITS - DATABITS + 1){1'b0}}, {(DATABITS - 1){1'b1}}};
   localparam logic signed [ACCBITS-1:0] SAT_MIN = ~SAT_MAX;

   state_t                     state;
   logic [PTRBITS-1:0]         wr_ptr;
   logic [PTRBITS-1:0]         k;
   logic [PTRBITS-1:0]         rd_addr;
   logic signed [ACCBITS-1:0]  acc;
   logic signed [ACCBITS-1:0]  prod_ext;
   logic signed [ACCBITS-1:0]  acc_shift;
   logic signed [DATABITS-1:0] tap_data;
   logic signed [DATABITS-1:0] sat_val;
   logic                       accept;

   // A flush in the same cycle as valid_in discards the sample.
   assign accept  = valid_in && ready_out && (state == IDLE) && !clr_in;
   // wr_ptr already points past the newest sample once MAC starts.
   assign rd_addr = wr_ptr - PTRBITS'(1) - k;

   fir_delayline #(
      .DATABITS (DATABITS),
      .TAPS     (TAPS),
      .PTRBITS  (PTRBITS)
   ) u_delayline (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr_in),
      .wr_en   (accept),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_addr (rd_addr),
      .rd_data (tap_data)
   );

   // Operands widened before multiplying so the product is formed at full accumulator width.
   assign prod_ext = ACCBITS'(COEFFS[k]) * ACCBITS'(tap_data);

   // NOTE: every branch assigns sat_val and acc_shift is set first, so no latch is inferred.
   always_comb begin
      acc_shift = acc >>> FRACBITS;
      if (acc_shift > SAT_MAX)
         sat_val = SAT_MAX[DATABITS-1:0];
      else if (acc_shift < SAT_MIN)
         sat_val = SAT_MIN[DATABITS-1:0];
      else
         sat_val = acc_shift[DATABITS-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         k         <= '0;
         acc       <= '0;
         data_out  <= '0;
         ld_out    <= 1'b0;
         clr_out   <= 1'b0;
         busy_out  <= 1'b0;
         ready_out <= 1'b0;
      end else begin
         clr_out <= clr_in;
         ld_out  <= 1'b0;
         if (clr_in) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            k         <= '0;
            acc       <= '0;
            busy_out  <= 1'b0;
            ready_out <= 1'b1;
         end else begin
            unique case (state)
               IDLE: begin
                  if (accept) begin
                     wr_ptr    <= wr_ptr + PTRBITS'(1);
                     acc       <= '0;
                     k         <= '0;
                     state     <= MAC;
                     busy_out  <= 1'b1;
                     ready_out <= 1'b0;
                  end else begin
                     ready_out <= 1'b1;
                  end
               end
               MAC: begin
                  acc <= acc + prod_ext;
                  k   <= k + PTRBITS'(1);
                  if (k == LAST_TAP) state <= OUT;
               end
               OUT: begin
                  data_out  <= sat_val;
                  ld_out    <= 1'b1;
                  state     <= IDLE;
                  busy_out  <= 1'b0;
                  ready_out <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fir_mac.sv
// Directed bench for fir_mac: reset, handshake timing, impulse/wrap, saturation, flush, abort.
module tb_fir_mac;

   import fir_filter_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_in = 1'b0;
   logic        valid_in = 1'b0;
   logic [15:0] data_in = '0;
   logic        ready_out;
   logic [15:0] data_out;
   logic        ld_out;
   logic        clr_out;
   logic        busy_out;

   int errors = 0;
   int checks = 0;

   always #(CLK_PERIOD / 2) clk = ~clk;

   fir_mac dut (
      .clk       (clk),
      .rst       (rst),
      .clr_in    (clr_in),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .ready_out (ready_out),
      .data_out  (data_out),
      .ld_out    (ld_out),
      .clr_out   (clr_out),
      .busy_out  (busy_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one sample and returns the result from its ld_out strobe.
   task automatic run_sample(input logic [15:0] s, output logic [15:0] res);
      int n;
      n = 0;
      while (!ready_out && n < 20) begin tick(); n++; end
      valid_in = 1'b1;
      data_in  = s;
      tick();
      valid_in = 1'b0;
      data_in  = '0;
      n = 0;
      while (!ld_out && n < 20) begin tick(); n++; end
      check("ld_seen", {31'd0, ld_out}, 32'd1);
      res = data_out;
   endtask

   task automatic count_ld(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (ld_out) cnt++;
      end
   endtask

   logic [15:0] res;
   logic [15:0] impulse_exp [9];
   int          cnt;

   initial begin
      impulse_exp = '{16'h2000, 16'h2000, 16'h2000, 16'h1000, 16'h0800,
                      16'h0400, 16'h0000, 16'h0000, 16'h0000};

      // Reset state
      tick();
      check("rst_outputs", {data_out, ready_out, ld_out, clr_out, busy_out}, 32'd0);
      #2 rst = 1'b0;
      check("rdy_before_edge", {31'd0, ready_out}, 32'd0);
      tick();
      check("rdy_after_release", {31'd0, ready_out}, 32'd1);

      // Handshake timing with valid_in held high
      valid_in = 1'b1;
      data_in  = 16'h0000;
      tick();
      check("accept_edge0", {ld_out, ready_out, busy_out}, 32'b001);
      for (int i = 1; i <= 8; i++) begin
         tick();
         check("busy_window", {ld_out, ready_out, busy_out}, 32'b001);
      end
      tick();
      check("edge9_result", {ld_out, ready_out, busy_out}, 32'b110);
      tick();
      check("edge10_reaccept", {ld_out, ready_out, busy_out}, 32'b001);
      valid_in = 1'b0;
      count_ld(12, cnt);
      check("one_ld_per_accept", cnt, 32'd1);

      // Impulse response, then history expiry after the write pointer wraps
      run_sample(16'h4000, res);
      check("impulse_0", res, impulse_exp[0]);
      for (int i = 1; i < 9; i++) begin
         run_sample(16'h0000, res);
         check("impulse_tail", res, impulse_exp[i]);
      end

      // Saturation in both directions
      run_sample(16'h7FFF, res);
      check("pos_first", res, 16'h3FFF);
      for (int i = 1; i < 8; i++) run_sample(16'h7FFF, res);
      check("pos_sat", res, 16'h7FFF);
      for (int i = 0; i < 8; i++) run_sample(16'h8000, res);
      check("neg_sat", res, 16'h8000);

      // Flush during MAC aborts the sample
      valid_in = 1'b1;
      data_in  = 16'h4000;
      tick();
      valid_in = 1'b0;
      tick(); tick(); tick();
      clr_in = 1'b1;
      tick();
      check("clr_strobe", {clr_out, ld_out, busy_out, ready_out}, 32'b1001);
      clr_in = 1'b0;
      tick();
      check("clr_one_cycle", {31'd0, clr_out}, 32'd0);
      count_ld(12, cnt);
      check("no_ld_after_clr", cnt, 32'd0);

      // Simultaneous valid_in and clr_in: sample discarded
      valid_in = 1'b1;
      clr_in   = 1'b1;
      data_in  = 16'h7FFF;
      tick();
      check("valid_clr_discard", {clr_out, busy_out}, 32'b10);
      valid_in = 1'b0;
      clr_in   = 1'b0;
      tick();
      run_sample(16'h4000, res);
      check("after_clr_no_history", res, 16'h2000);

      // Asynchronous reset in the middle of MAC
      valid_in = 1'b1;
      data_in  = 16'h4000;
      tick();
      valid_in = 1'b0;
      tick(); tick(); tick();
      #2 rst = 1'b1;
      #1;
      check("async_rst_outputs", {data_out, ready_out, ld_out, clr_out, busy_out}, 32'd0);
      #2 rst = 1'b0;
      check("rst_rdy_low", {31'd0, ready_out}, 32'd0);
      tick();
      check("rst_rdy_high", {31'd0, ready_out}, 32'd1);
      count_ld(12, cnt);
      check("no_ld_after_rst", cnt, 32'd0);
      check("data_after_rst", data_out, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
